// File: rtl/ahb_copy_master.sv
// AHB master that copies a block of 32-bit words with SINGLE/NONSEQ read-write pairs.
// Arbitrates per job, re-arbitrates on grant loss, and aborts on any non-OKAY response.
module ahb_copy_master #(
  parameter int LEN_W = 16
) (
  input  logic             hclk,
  input  logic             hresetn,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             hbusreq,
  output logic             hlock,
  input  logic             hgrant,
  output logic [31:0]      haddr,
  output logic [1:0]       htrans,
  output logic             hwrite,
  output logic [2:0]       hsize,
  output logic [2:0]       hburst,
  output logic [3:0]       hprot,
  output logic [31:0]      hwdata,
  input  logic [31:0]      hrdata,
  input  logic             hready,
  input  logic [1:0]       hresp
);

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_RADDR, S_RDATA, S_WADDR, S_WDATA} state_t;

  state_t           r_state, w_nxt;
  logic [31:0]      r_src, r_dst, r_buf;
  logic [LEN_W-1:0] r_cnt;
  logic             r_pend_wr, r_done, r_err;

  logic w_fault, w_dphase;
  assign w_fault  = (hresp != 2'b00);
  assign w_dphase = (r_state == S_RDATA) || (r_state == S_WDATA);

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) r_state <= S_IDLE;
    else          r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start && (len != '0)) w_nxt = S_ARB;
      S_ARB:   if (hgrant && hready) w_nxt = r_pend_wr ? S_WADDR : S_RADDR;
      S_RADDR: if (hready) w_nxt = S_RDATA;
      S_RDATA: begin
        if (hready) begin
          if (w_fault)     w_nxt = S_IDLE;
          else if (hgrant) w_nxt = S_WADDR;
          else             w_nxt = S_ARB;
        end
      end
      S_WADDR: if (hready) w_nxt = S_WDATA;
      S_WDATA: begin
        if (hready) begin
          if (w_fault || (r_cnt == LEN_W'(1))) w_nxt = S_IDLE;
          else if (hgrant)                     w_nxt = S_RADDR;
          else                                 w_nxt = S_ARB;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // Job registers; pend_wr tracks which half of the word pair is still owed after ARB.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_src     <= '0;
      r_dst     <= '0;
      r_buf     <= '0;
      r_cnt     <= '0;
      r_pend_wr <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_err <= 1'b0;
            if (len != '0) begin
              r_src     <= {src_addr[31:2], 2'b00};
              r_dst     <= {dst_addr[31:2], 2'b00};
              r_cnt     <= len;
              r_pend_wr <= 1'b0;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_RDATA: begin
          if (hready && w_fault) begin
            r_err  <= 1'b1;
            r_done <= 1'b1;
          end else if (hready) begin
            r_buf     <= hrdata;
            r_src     <= r_src + 32'd4;
            r_pend_wr <= 1'b1;
          end
        end
        S_WDATA: begin
          if (hready && w_fault) begin
            r_err  <= 1'b1;
            r_done <= 1'b1;
          end else if (hready) begin
            r_dst     <= r_dst + 32'd4;
            r_cnt     <= r_cnt - 1'b1;
            r_pend_wr <= 1'b0;
            if (r_cnt == LEN_W'(1)) r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy    = (r_state != S_IDLE);
    done    = r_done;
    err     = r_err;
    // Release the bus as soon as an error response is seen.
    hbusreq = busy && !(w_dphase && w_fault);
    hlock   = 1'b0;
    htrans  = 2'b00;
    haddr   = '0;
    hwrite  = 1'b0;
    if (r_state == S_RADDR) begin
      htrans = 2'b10;
      haddr  = r_src;
    end else if (r_state == S_WADDR) begin
      htrans = 2'b10;
      haddr  = r_dst;
      hwrite = 1'b1;
    end
    hwdata = r_buf;
    hsize  = 3'b010;
    hburst = 3'b000;
    hprot  = 4'b0011;
  end

endmodule

// File: tb/tb_ahb_copy_master.sv
// Bench for ahb_copy_master: behavioural AHB slave with memory, wait states, error
// injection and grant control; table-driven copy jobs plus reset and len=0 sequences.
module tb_ahb_copy_master;
  localparam int LEN_W = 16;

  logic             hclk = 1'b0, hresetn = 1'b0, start = 1'b0;
  logic [31:0]      src_addr = '0, dst_addr = '0;
  logic [LEN_W-1:0] len = '0;
  logic             busy, done, err, hbusreq, hlock, hwrite;
  logic             hgrant = 1'b1, hready = 1'b1;
  logic [1:0]       hresp = 2'b00, htrans;
  logic [31:0]      hrdata = '0, haddr, hwdata;
  logic [2:0]       hsize, hburst;
  logic [3:0]       hprot;

  always #5 hclk = ~hclk;

  ahb_copy_master #(.LEN_W(LEN_W)) dut (
    .hclk(hclk), .hresetn(hresetn), .start(start), .src_addr(src_addr),
    .dst_addr(dst_addr), .len(len), .busy(busy), .done(done), .err(err),
    .hbusreq(hbusreq), .hlock(hlock), .hgrant(hgrant), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
    .hprot(hprot), .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  int vec_n = 0, miss_n = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_n++;
    if (act !== exp) begin
      miss_n++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int idx(input logic [31:0] a);
    return int'(a[11:2]);
  endfunction

  // Slave configuration (written by the stimulus) and slave state (written by the slave only).
  int          waits = 0;
  bit          err_en = 1'b0, gdrop_en = 1'b0;
  logic [31:0] err_addr = '0;
  int          gtok = 0, gtok_seen = 0;

  logic [31:0] mem [0:1023];
  bit          loaded = 1'b0;
  bit          d_act = 1'b0, d_wr = 1'b0;
  logic [31:0] d_addr = '0, p_haddr = '0, p_hwdata = '0;
  logic [1:0]  p_htrans = 2'b00;
  logic        p_hwrite = 1'b0;
  int          wcnt = 0, gleft = 0;
  int          rd_cnt = 0, wr_cnt = 0, done_cnt = 0, stab_viol = 0, nonseq_cnt = 0;
  int          cyc = 0;

  always @(posedge hclk) cyc <= cyc + 1;

  // Slave acts at the falling edge on what happened at the preceding rising edge.
  always @(negedge hclk) begin
    if (!hresetn) begin
      if (!loaded) begin
        for (int i = 0; i < 1024; i++)
          mem[i] = (i < 4) ? 32'h11111111 * 32'(i + 1) : (32'hC0DE0000 | 32'(i));
        loaded = 1'b1;
      end
      d_act = 1'b0; wcnt = 0; gleft = 0;
      hready = 1'b1; hresp = 2'b00; hgrant = 1'b1;
      p_htrans = 2'b00; p_haddr = '0; p_hwrite = 1'b0; p_hwdata = '0;
    end else begin
      if (!hready && p_htrans == 2'b10 &&
          (haddr !== p_haddr || htrans !== 2'b10 || hwrite !== p_hwrite)) stab_viol++;
      if (!hready && d_act && d_wr && hwdata !== p_hwdata) stab_viol++;
      if (d_act && hready) begin
        if (hresp == 2'b00 && d_wr) mem[idx(d_addr)] = p_hwdata;
        d_act = 1'b0;
      end
      if (gleft > 0) begin
        gleft--;
        if (gleft == 0) hgrant = 1'b1;
      end
      if (p_htrans == 2'b10 && hready) begin
        d_act = 1'b1; d_addr = p_haddr; d_wr = p_hwrite;
        if (d_wr) wr_cnt++;
        else begin
          rd_cnt++;
          if (gdrop_en && gtok_seen != gtok) begin
            gtok_seen = gtok; hgrant = 1'b0; gleft = 3;
          end
        end
      end
      if (hready) wcnt = 0; else wcnt++;
      if (done) done_cnt++;
      if (htrans == 2'b10) nonseq_cnt++;
      p_htrans = htrans; p_haddr = haddr; p_hwrite = hwrite; p_hwdata = hwdata;
      if (d_act && err_en && d_addr == err_addr) begin
        hresp = 2'b01; hready = (wcnt >= 1);
      end else begin
        hresp = 2'b00; hready = (htrans == 2'b10 || d_act) ? (wcnt >= waits) : 1'b1;
      end
      hrdata = (d_act && !d_wr) ? mem[idx(d_addr)] : 32'hDEADBEEF;
    end
  end

  typedef struct {
    logic [31:0] src, dst;
    int          len, waits;
    bit          gdrop, err_en;
    logic [31:0] err_addr;
    int          cyc;
    bit          err;
    int          rd, wr, nchk;
    bit          restart;
  } vec_t;

  task automatic run(input vec_t v, input string tag);
    int t0, b_rd, b_wr, b_dn, b_st;
    bit got;
    logic [31:0] snap [8];
    waits = v.waits; err_en = v.err_en; err_addr = v.err_addr; gdrop_en = v.gdrop; gtok++;
    for (int i = 0; i < 8; i++) snap[i] = mem[idx((v.src & ~32'h3) + 32'(4 * i))];
    b_rd = rd_cnt; b_wr = wr_cnt; b_dn = done_cnt; b_st = stab_viol;
    @(posedge hclk); #1;
    src_addr = v.src; dst_addr = v.dst; len = LEN_W'(v.len); start = 1'b1; t0 = cyc;
    @(posedge hclk); #1;
    start = 1'b0;
    if (v.restart) begin
      repeat (4) begin @(posedge hclk); #1; end
      src_addr = 32'h0; dst_addr = 32'hE00; len = LEN_W'(2); start = 1'b1;
      @(posedge hclk); #1;
      start = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      if (done) got = 1'b1;
      else begin @(posedge hclk); #1; end
    end
    chk({tag, " done_seen"}, 32'(got), 32'd1);
    chk({tag, " latency"}, 32'(cyc - t0), 32'(v.cyc));
    chk({tag, " err_at_done"}, 32'(err), 32'(v.err));
    chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
    chk({tag, " hbusreq_at_done"}, 32'(hbusreq), 32'd0);
    @(posedge hclk); #1;
    chk({tag, " done_width"}, 32'(done), 32'd0);
    repeat (2) begin @(posedge hclk); #1; end
    chk({tag, " err_sticky"}, 32'(err), 32'(v.err));
    chk({tag, " reads"}, 32'(rd_cnt - b_rd), 32'(v.rd));
    chk({tag, " writes"}, 32'(wr_cnt - b_wr), 32'(v.wr));
    chk({tag, " done_pulses"}, 32'(done_cnt - b_dn), 32'd1);
    chk({tag, " stable"}, 32'(stab_viol - b_st), 32'd0);
    for (int i = 0; i < v.nchk; i++)
      chk({tag, " data"}, mem[idx((v.dst & ~32'h3) + 32'(4 * i))], snap[i]);
  endtask

  vec_t vt [9];

  initial begin
    int b_ns, b_dn, b_wr;
    bit found;
    //          src           dst       len w gd ee err_addr cyc e rd wr nchk rs
    vt[0] = '{32'h0000_0000, 32'h100, 4, 0, 0, 0, 32'h0,   18, 0, 4, 4, 4, 0};
    vt[1] = '{32'h0000_0010, 32'h200, 2, 2, 0, 0, 32'h0,   26, 0, 2, 2, 2, 0};
    vt[2] = '{32'h0000_0020, 32'h300, 2, 0, 1, 0, 32'h0,   13, 0, 2, 2, 2, 0};
    vt[3] = '{32'h0000_0000, 32'h800, 4, 0, 0, 1, 32'h804, 11, 1, 2, 2, 1, 0};
    vt[4] = '{32'h0000_0040, 32'h900, 4, 0, 0, 1, 32'h48,  13, 1, 3, 2, 2, 0};
    vt[5] = '{32'h0000_0000, 32'hA00, 3, 0, 0, 0, 32'h0,   14, 0, 3, 3, 3, 0};
    vt[6] = '{32'hFFFF_FFF8, 32'hB00, 3, 0, 0, 0, 32'h0,   14, 0, 3, 3, 3, 0};
    vt[7] = '{32'h0000_0053, 32'hC02, 1, 1, 0, 0, 32'h0,   10, 0, 1, 1, 1, 0};
    vt[8] = '{32'h0000_0060, 32'hD00, 8, 0, 0, 0, 32'h0,   34, 0, 8, 8, 8, 1};

    #12;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst hbusreq", 32'(hbusreq), 32'd0);
    chk("rst hlock", 32'(hlock), 32'd0);
    chk("rst hwrite", 32'(hwrite), 32'd0);
    chk("rst htrans", 32'(htrans), 32'd0);
    chk("rst haddr", haddr, 32'd0);
    chk("rst hwdata", hwdata, 32'd0);
    chk("rst hsize", 32'(hsize), 32'h2);
    chk("rst hburst", 32'(hburst), 32'h0);
    chk("rst hprot", 32'(hprot), 32'h3);
    @(posedge hclk); #1;
    hresetn = 1'b1;
    repeat (2) begin @(posedge hclk); #1; end

    // len=0: done the next cycle with no bus activity.
    b_ns = nonseq_cnt; b_dn = done_cnt;
    len = '0; src_addr = 32'h40; dst_addr = 32'h400; start = 1'b1;
    @(posedge hclk); #1;
    start = 1'b0;
    chk("len0 done", 32'(done), 32'd1);
    chk("len0 busy", 32'(busy), 32'd0);
    repeat (3) begin @(posedge hclk); #1; end
    chk("len0 nonseq", 32'(nonseq_cnt - b_ns), 32'd0);
    chk("len0 done_pulses", 32'(done_cnt - b_dn), 32'd1);

    for (int i = 0; i < 9; i++) run(vt[i], $sformatf("v%0d", i));

    // Asynchronous reset in the address phase of word 3.
    waits = 0; err_en = 1'b0; gdrop_en = 1'b0;
    b_wr = wr_cnt; b_dn = done_cnt;
    @(posedge hclk); #1;
    src_addr = 32'h0; dst_addr = 32'hF00; len = LEN_W'(4); start = 1'b1;
    @(posedge hclk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge hclk); #1;
      if (htrans == 2'b10 && hwrite && (wr_cnt - b_wr) == 2) found = 1'b1;
    end
    chk("midrst reached_waddr3", 32'(found), 32'd1);
    chk("midrst haddr_before", haddr, 32'hF08);
    #2 hresetn = 1'b0;
    #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst hbusreq", 32'(hbusreq), 32'd0);
    chk("midrst htrans", 32'(htrans), 32'd0);
    chk("midrst haddr", haddr, 32'd0);
    chk("midrst hwrite", 32'(hwrite), 32'd0);
    chk("midrst hwdata", hwdata, 32'd0);
    @(posedge hclk); #1;
    hresetn = 1'b1;
    repeat (4) begin @(posedge hclk); #1; end
    chk("midrst no_done", 32'(done_cnt - b_dn), 32'd0);
    chk("midrst idle_after", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
    $finish;
  end

endmodule
